// File: rtl/accelerator_state_feedback_if.sv
// Stream/handshake bundle for the output-feedback stage u = -K*y + r.
// The master drives sizes, operands and strobes. The slave returns u and READY.
interface accelerator_state_feedback_if #(
  parameter int unsigned DATA_SIZE = 64
);
  logic                 start;
  logic                 ready;
  logic                 data_k_in_i_enable;
  logic                 data_k_in_j_enable;
  logic                 data_y_in_enable;
  logic                 data_r_in_enable;
  logic                 data_u_out_enable;
  logic [DATA_SIZE-1:0] size_k_i_in;
  logic [DATA_SIZE-1:0] size_k_j_in;
  logic [DATA_SIZE-1:0] data_k_in;
  logic [DATA_SIZE-1:0] data_y_in;
  logic [DATA_SIZE-1:0] data_r_in;
  logic [DATA_SIZE-1:0] data_u_out;

  modport master (
    output start, data_k_in_i_enable, data_k_in_j_enable, data_y_in_enable, data_r_in_enable,
    output size_k_i_in, size_k_j_in, data_k_in, data_y_in, data_r_in,
    input  ready, data_u_out_enable, data_u_out
  );

  modport slave (
    input  start, data_k_in_i_enable, data_k_in_j_enable, data_y_in_enable, data_r_in_enable,
    input  size_k_i_in, size_k_j_in, data_k_in, data_y_in, data_r_in,
    output ready, data_u_out_enable, data_u_out
  );
endinterface

// File: rtl/accelerator_state_feedback.sv
// Output-feedback stage: buffers y, then streams u(i) = r(i) - sum_j K(i,j)*y(j).
// There is one signed fixed-point MAC per accepted K element, and u is registered one cycle later.
module accelerator_state_feedback #(
  parameter int unsigned DATA_SIZE     = 64,
  parameter int unsigned CONTROL_SIZE  = 64,
  parameter int unsigned FRACTION_SIZE = 0,
  parameter int unsigned MAX_SIZE      = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  accelerator_state_feedback_if.slave    bus
);

  localparam int unsigned IdxW = (MAX_SIZE > 1) ? $clog2(MAX_SIZE) : 1;
  localparam logic [CONTROL_SIZE-1:0] CtrlOne = CONTROL_SIZE'(1);
  localparam logic [CONTROL_SIZE-1:0] MaxQ    = CONTROL_SIZE'(MAX_SIZE);

  typedef enum logic [1:0] {StIdle, StLoadY, StLoadR, StMac} state_e;

  state_e                    state_q, state_d;
  logic [CONTROL_SIZE-1:0]   p_q, p_d, q_q, q_d, i_q, i_d, j_q, j_d;
  logic [DATA_SIZE-1:0]      acc_q, acc_d, u_q, u_d;
  logic                      u_en_q, u_en_d, ready_q, ready_d;
  logic                      y_we;
  logic [DATA_SIZE-1:0]      y_mem [MAX_SIZE];

  logic [CONTROL_SIZE-1:0]   p_in, q_in, q_clamp;
  logic [DATA_SIZE-1:0]      y_rd, term, acc_sub;
  logic signed [2*DATA_SIZE-1:0] prod;

  assign p_in    = CONTROL_SIZE'(bus.size_k_i_in);
  assign q_in    = CONTROL_SIZE'(bus.size_k_j_in);
  assign q_clamp = (q_in > MaxQ) ? MaxQ : q_in;

  // Full-width signed product, rescaled by the fraction bits and truncated (wraps, no saturation).
  assign y_rd    = y_mem[j_q[IdxW-1:0]];
  assign prod    = $signed({{DATA_SIZE{bus.data_k_in[DATA_SIZE-1]}}, bus.data_k_in})
                 * $signed({{DATA_SIZE{y_rd[DATA_SIZE-1]}}, y_rd});
  assign term    = DATA_SIZE'(prod >>> FRACTION_SIZE);
  assign acc_sub = acc_q - term;

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    q_d     = q_q;
    i_d     = i_q;
    j_d     = j_q;
    acc_d   = acc_q;
    u_d     = u_q;
    u_en_d  = 1'b0;
    ready_d = 1'b0;
    y_we    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          p_d = p_in;
          q_d = q_clamp;
          if (p_in == '0 || q_clamp == '0) begin
            ready_d = 1'b1;
          end else begin
            j_d     = '0;
            state_d = StLoadY;
          end
        end
      end
      StLoadY: begin
        if (bus.data_y_in_enable) begin
          y_we = 1'b1;
          j_d  = j_q + CtrlOne;
          if (j_q == q_q - CtrlOne) begin
            i_d     = '0;
            state_d = StLoadR;
          end
        end
      end
      StLoadR: begin
        if (bus.data_r_in_enable) begin
          acc_d   = bus.data_r_in;
          j_d     = '0;
          state_d = StMac;
        end
      end
      StMac: begin
        if (bus.data_k_in_j_enable) begin
          acc_d = acc_sub;
          j_d   = j_q + CtrlOne;
          if (j_q == q_q - CtrlOne) begin
            u_d    = acc_sub;
            u_en_d = 1'b1;
            i_d    = i_q + CtrlOne;
            if (i_q + CtrlOne < p_q) begin
              state_d = StLoadR;
            end else begin
              ready_d = 1'b1;
              state_d = StIdle;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      p_q     <= '0;
      q_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      acc_q   <= '0;
      u_q     <= '0;
      u_en_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      q_q     <= q_d;
      i_q     <= i_d;
      j_q     <= j_d;
      acc_q   <= acc_d;
      u_q     <= u_d;
      u_en_q  <= u_en_d;
      ready_q <= ready_d;
    end
  end

  // The y buffer needs no reset: it is always fully reloaded before it is read.
  always_ff @(posedge clk) begin
    if (y_we) begin
      y_mem[j_q[IdxW-1:0]] <= bus.data_y_in;
    end
  end

  assign bus.ready             = ready_q;
  assign bus.data_u_out_enable = u_en_q;
  assign bus.data_u_out        = u_q;

endmodule

// File: tb/tb_accelerator_state_feedback.sv
// Directed bench for accelerator_state_feedback.
// dut0 uses integer data (FRACTION_SIZE=0). dut1 sees the same inputs with FRACTION_SIZE=8.
module tb_accelerator_state_feedback;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   u_pulses = 0;
  int   ready_pulses = 0;

  always #5 clk = ~clk;

  accelerator_state_feedback_if #(.DATA_SIZE(64)) ifa ();
  accelerator_state_feedback_if #(.DATA_SIZE(64)) ifb ();

  assign ifb.start              = ifa.start;
  assign ifb.data_k_in_i_enable = ifa.data_k_in_i_enable;
  assign ifb.data_k_in_j_enable = ifa.data_k_in_j_enable;
  assign ifb.data_y_in_enable   = ifa.data_y_in_enable;
  assign ifb.data_r_in_enable   = ifa.data_r_in_enable;
  assign ifb.size_k_i_in        = ifa.size_k_i_in;
  assign ifb.size_k_j_in        = ifa.size_k_j_in;
  assign ifb.data_k_in          = ifa.data_k_in;
  assign ifb.data_y_in          = ifa.data_y_in;
  assign ifb.data_r_in          = ifa.data_r_in;

  accelerator_state_feedback #(
    .DATA_SIZE(64), .CONTROL_SIZE(64), .FRACTION_SIZE(0), .MAX_SIZE(16)
  ) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  accelerator_state_feedback #(
    .DATA_SIZE(64), .CONTROL_SIZE(64), .FRACTION_SIZE(8), .MAX_SIZE(16)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  always @(posedge clk) begin
    if (ifa.data_u_out_enable) u_pulses++;
    if (ifa.ready) ready_pulses++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [63:0] p, input logic [63:0] q);
    ifa.start = 1'b1;
    ifa.size_k_i_in = p;
    ifa.size_k_j_in = q;
    step();
    ifa.start = 1'b0;
  endtask

  task automatic send_y(input logic [63:0] v);
    ifa.data_y_in_enable = 1'b1;
    ifa.data_y_in = v;
    step();
    ifa.data_y_in_enable = 1'b0;
  endtask

  task automatic send_r(input logic [63:0] v);
    ifa.data_r_in_enable = 1'b1;
    ifa.data_r_in = v;
    step();
    ifa.data_r_in_enable = 1'b0;
  endtask

  task automatic send_k(input logic [63:0] v, input logic first);
    ifa.data_k_in_j_enable = 1'b1;
    ifa.data_k_in_i_enable = first;
    ifa.data_k_in = v;
    step();
    ifa.data_k_in_j_enable = 1'b0;
    ifa.data_k_in_i_enable = 1'b0;
  endtask

  task automatic pause(input int gap_max);
    if (gap_max > 0) repeat ($urandom_range(1, gap_max)) step();
  endtask

  // P=Q=2, y=[3,4], K=[[1,2],[5,-1]], r=[10,20]: u = [-1, 9].
  task automatic run_basic(input int gap_max, input string tag);
    int u0;
    int r0;
    u0 = u_pulses;
    r0 = ready_pulses;
    do_start(64'd2, 64'd2); pause(gap_max);
    send_y(64'd3);          pause(gap_max);
    send_y(64'd4);          pause(gap_max);
    send_r(64'd10);         pause(gap_max);
    send_k(64'd1, 1'b1);    pause(gap_max);
    vectors++;
    if (ifa.data_u_out_enable !== 1'b0) begin
      miscompares++;
      $display("FAIL %s early_u_en: got %b want 0", tag, ifa.data_u_out_enable);
    end
    send_k(64'd2, 1'b0);
    vectors++;
    if (ifa.data_u_out_enable !== 1'b1 || ifa.data_u_out !== -64'sd1 || ifa.ready !== 1'b0) begin
      miscompares++;
      $display("FAIL %s row0: en=%b u=%h ready=%b want en=1 u=%h ready=0", tag,
               ifa.data_u_out_enable, ifa.data_u_out, ifa.ready, -64'sd1);
    end
    if (gap_max > 0) begin
      step();
      vectors++;
      if (ifa.data_u_out_enable !== 1'b0 || ifa.data_u_out !== -64'sd1) begin
        miscompares++;
        $display("FAIL %s row0_hold: en=%b u=%h want en=0 u=%h", tag,
                 ifa.data_u_out_enable, ifa.data_u_out, -64'sd1);
      end
      repeat ($urandom_range(0, gap_max - 1)) step();
    end
    send_r(64'd20);         pause(gap_max);
    send_k(64'd5, 1'b1);    pause(gap_max);
    send_k(-64'sd1, 1'b0);
    vectors++;
    if (ifa.data_u_out_enable !== 1'b1 || ifa.data_u_out !== 64'd9 || ifa.ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s row1: en=%b u=%h ready=%b want en=1 u=9 ready=1", tag,
               ifa.data_u_out_enable, ifa.data_u_out, ifa.ready);
    end
    step();
    vectors++;
    if (ifa.data_u_out_enable !== 1'b0 || ifa.ready !== 1'b0 || ifa.data_u_out !== 64'd9) begin
      miscompares++;
      $display("FAIL %s after: en=%b ready=%b u=%h want en=0 ready=0 u=9", tag,
               ifa.data_u_out_enable, ifa.ready, ifa.data_u_out);
    end
    vectors++;
    if (u_pulses - u0 != 2 || ready_pulses - r0 != 1) begin
      miscompares++;
      $display("FAIL %s pulse_count: u=%0d ready=%0d want u=2 ready=1", tag,
               u_pulses - u0, ready_pulses - r0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    vectors++;
    if (ifa.ready !== 1'b0 || ifa.data_u_out_enable !== 1'b0 || ifa.data_u_out !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_dut0: ready=%b en=%b u=%h want 0 0 0", ifa.ready,
               ifa.data_u_out_enable, ifa.data_u_out);
    end
    vectors++;
    if (ifb.ready !== 1'b0 || ifb.data_u_out_enable !== 1'b0 || ifb.data_u_out !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_dut1: ready=%b en=%b u=%h want 0 0 0", ifb.ready,
               ifb.data_u_out_enable, ifb.data_u_out);
    end
  endtask

  task automatic test_back_to_back();
    run_basic(0, "b2b");
  endtask

  task automatic test_gaps();
    run_basic(3, "gaps");
  endtask

  task automatic test_zero_size();
    int u0;
    u0 = u_pulses;
    do_start(64'd0, 64'd2);
    vectors++;
    if (ifa.ready !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_p_ready: got %b want 1", ifa.ready);
    end
    step();
    do_start(64'd3, 64'd0);
    vectors++;
    if (ifa.ready !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_q_ready: got %b want 1", ifa.ready);
    end
    step();
    step();
    vectors++;
    if (ifa.ready !== 1'b0 || u_pulses != u0) begin
      miscompares++;
      $display("FAIL zero_quiet: ready=%b u_pulses=%0d want 0 and 0", ifa.ready, u_pulses - u0);
    end
  endtask

  task automatic test_fraction();
    do_start(64'd1, 64'd1);
    send_y(64'h180);
    send_r(64'h100);
    send_k(64'h200, 1'b1);
    vectors++;
    if (ifb.data_u_out_enable !== 1'b1 || ifb.data_u_out !== 64'hFFFF_FFFF_FFFF_FE00
        || ifb.ready !== 1'b1) begin
      miscompares++;
      $display("FAIL fraction: en=%b u=%h ready=%b want en=1 u=fffffffffffffe00 ready=1",
               ifb.data_u_out_enable, ifb.data_u_out, ifb.ready);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int u0;
    int r0;
    do_start(64'd3, 64'd2);
    send_y(64'd3);
    send_y(64'd4);
    send_r(64'd10);
    send_k(64'd1, 1'b1);
    send_k(64'd2, 1'b0);
    send_r(64'd20);
    send_k(64'd5, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    u0 = u_pulses;
    r0 = ready_pulses;
    send_k(-64'sd1, 1'b0);
    send_r(64'd7);
    send_y(64'd1);
    step();
    step();
    vectors++;
    if (u_pulses != u0 || ready_pulses != r0 || ifa.data_u_out !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_mid_quiet: u_pulses=%0d ready_pulses=%0d u=%h want 0 0 0",
               u_pulses - u0, ready_pulses - r0, ifa.data_u_out);
    end
    run_basic(0, "post_reset");
  endtask

  task automatic test_overflow();
    do_start(64'd1, 64'd1);
    send_y(64'd1);
    send_r(64'h7FFF_FFFF_FFFF_FFFF);
    send_k(-64'sd1, 1'b1);
    vectors++;
    if (ifa.data_u_out_enable !== 1'b1 || ifa.data_u_out !== 64'h8000_0000_0000_0000) begin
      miscompares++;
      $display("FAIL overflow: en=%b u=%h want en=1 u=8000000000000000",
               ifa.data_u_out_enable, ifa.data_u_out);
    end
    step();
  endtask

  // P=1, Q=2, y=[1,2], r=10, K=[1,2]: u = 5 despite stray strobes and START pulses.
  task automatic test_ignore_rules();
    int r0;
    do_start(64'd1, 64'd2);
    send_k(64'd100, 1'b1);
    send_y(64'd1);
    r0 = ready_pulses;
    do_start(64'd0, 64'd0);
    send_y(64'd2);
    send_y(64'd7);
    do_start(64'd0, 64'd0);
    ifa.data_k_in_j_enable = 1'b1;
    ifa.data_k_in = 64'd1000;
    send_r(64'd10);
    ifa.data_k_in_j_enable = 1'b0;
    send_r(64'd99);
    do_start(64'd0, 64'd0);
    vectors++;
    if (ready_pulses != r0 || ifa.ready !== 1'b0) begin
      miscompares++;
      $display("FAIL start_ignored: ready_pulses=%0d ready=%b want 0 0", ready_pulses - r0,
               ifa.ready);
    end
    send_k(64'd1, 1'b1);
    send_k(64'd2, 1'b0);
    vectors++;
    if (ifa.data_u_out_enable !== 1'b1 || ifa.data_u_out !== 64'd5 || ifa.ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ignore_result: en=%b u=%h ready=%b want en=1 u=5 ready=1",
               ifa.data_u_out_enable, ifa.data_u_out, ifa.ready);
    end
    step();
  endtask

  initial begin
    ifa.start = 1'b0;
    ifa.data_k_in_i_enable = 1'b0;
    ifa.data_k_in_j_enable = 1'b0;
    ifa.data_y_in_enable = 1'b0;
    ifa.data_r_in_enable = 1'b0;
    ifa.size_k_i_in = '0;
    ifa.size_k_j_in = '0;
    ifa.data_k_in = '0;
    ifa.data_y_in = '0;
    ifa.data_r_in = '0;
    test_reset();
    test_back_to_back();
    test_gaps();
    test_zero_size();
    test_fraction();
    test_reset_mid();
    test_overflow();
    test_ignore_rules();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
